gcd_rr_scheduler: RTL and testbench



---
 rtl/gcd_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/gcd_rr_scheduler.sv | 137 +++++++++++++
 tb/tb_gcd_rr_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD scheduler slice.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RETURN = 2'd3
  } sched_state_t;

  // Default operand/result width of the shared GCD unit.
  localparam int unsigned GCD_WL = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins,
// wrapping modulo N (N need not be a power of two).
module rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           any_req
);

  int unsigned     idx;
  logic [IDW-1:0]  sel;

  // Scan ptr, ptr+1, ... modulo N and keep the first active request.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      sel = IDW'(idx);
      if (!any_req && req[sel]) begin
        any_req    = 1'b1;
        grant[sel] = 1'b1;
        grant_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/gcd_rr_scheduler.sv
// Round-robin sharing of one GCD unit among NREQ requesters; one operation
// outstanding at a time, result routed back to the issuing requester.
module gcd_rr_scheduler
  import gcd_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned WL   = GCD_WL,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [NREQ-1:0]   req_val,
  output logic [NREQ-1:0]   req_rdy,
  input  logic [NREQ*WL-1:0] req_a,
  input  logic [NREQ*WL-1:0] req_b,
  output logic [NREQ-1:0]   resp_val,
  input  logic [NREQ-1:0]   resp_rdy,
  output logic [WL-1:0]     resp_data,
  output logic              gcd_ops_val,
  input  logic              gcd_ops_rdy,
  output logic [WL-1:0]     gcd_ops_a,
  output logic [WL-1:0]     gcd_ops_b,
  input  logic              gcd_res_val,
  output logic              gcd_res_rdy,
  input  logic [WL-1:0]     gcd_res,
  output logic              busy,
  output logic [IDW-1:0]    owner
);

  sched_state_t    state, state_n;
  logic [IDW-1:0]  rr_ptr;
  logic [WL-1:0]   op_a, op_b, res_q;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            any_req;
  logic [NREQ-1:0] req_rdy_c;
  logic [WL-1:0]   sel_a, sel_b;
  logic            accept, res_take, resp_done;

  rr_arbiter #(.N(NREQ), .IDW(IDW)) u_arb (
    .req       (req_val),
    .ptr       (rr_ptr),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .any_req   (any_req)
  );

  // Operand mux for the winning requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_a = req_a[i*WL +: WL];
        sel_b = req_b[i*WL +: WL];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_n     = state;
    req_rdy_c   = '0;
    gcd_ops_val = 1'b0;
    gcd_res_rdy = 1'b0;
    resp_val    = '0;
    accept      = 1'b0;
    res_take    = 1'b0;
    resp_done   = 1'b0;
    case (state)
      IDLE: begin
        req_rdy_c = gnt;
        if (any_req) begin
          accept  = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        gcd_ops_val = 1'b1;
        if (gcd_ops_rdy) state_n = WAIT;
      end
      WAIT: begin
        gcd_res_rdy = 1'b1;
        if (gcd_res_val) begin
          res_take = 1'b1;
          state_n  = RETURN;
        end
      end
      RETURN: begin
        resp_val[owner] = 1'b1;
        if (resp_rdy[owner]) begin
          resp_done = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The grant is combinational from req_val, so it is masked while reset is
  // asserted to keep every ready low during reset.
  assign req_rdy   = req_rdy_c & {NREQ{rst_b}};
  assign busy      = (state != IDLE);
  assign gcd_ops_a = op_a;
  assign gcd_ops_b = op_b;
  assign resp_data = res_q;

  // Operand/result capture, owner tracking and round-robin pointer update.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rr_ptr <= '0;
      owner  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      res_q  <= '0;
    end else begin
      if (accept) begin
        op_a  <= sel_a;
        op_b  <= sel_b;
        owner <= gnt_idx;
      end
      if (res_take) res_q <= gcd_res;
      if (resp_done) begin
        owner  <= '0;
        rr_ptr <= (owner == IDW'(NREQ - 1)) ? '0 : owner + IDW'(1);
      end
    end
  end

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Directed bench for gcd_rr_scheduler; the bench plays the GCD unit and
// supplies hand-computed results.
module tb_gcd_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [3:0]  req_val, req_rdy, resp_val, resp_rdy;
  logic [31:0] req_a, req_b;
  logic [7:0]  resp_data, gcd_ops_a, gcd_ops_b, gcd_res;
  logic        gcd_ops_val, gcd_ops_rdy, gcd_res_val, gcd_res_rdy, busy;
  logic [1:0]  owner;

  // Second instance with a non-power-of-two requester count.
  logic [2:0]  b_req_val, b_req_rdy, b_resp_val;
  logic [23:0] b_req_a, b_req_b;
  logic [7:0]  b_resp_data, b_ops_a, b_ops_b;
  logic        b_ops_val, b_res_rdy, b_busy;
  logic [1:0]  b_owner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gcd_rr_scheduler #(.NREQ(4), .WL(8)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_val(req_val), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data),
    .gcd_ops_val(gcd_ops_val), .gcd_ops_rdy(gcd_ops_rdy),
    .gcd_ops_a(gcd_ops_a), .gcd_ops_b(gcd_ops_b),
    .gcd_res_val(gcd_res_val), .gcd_res_rdy(gcd_res_rdy), .gcd_res(gcd_res),
    .busy(busy), .owner(owner)
  );

  gcd_rr_scheduler #(.NREQ(3), .WL(8)) dut3 (
    .clk(clk), .rst_b(rst_b),
    .req_val(b_req_val), .req_rdy(b_req_rdy), .req_a(b_req_a), .req_b(b_req_b),
    .resp_val(b_resp_val), .resp_rdy(3'b111), .resp_data(b_resp_data),
    .gcd_ops_val(b_ops_val), .gcd_ops_rdy(1'b1),
    .gcd_ops_a(b_ops_a), .gcd_ops_b(b_ops_b),
    .gcd_res_val(1'b1), .gcd_res_rdy(b_res_rdy), .gcd_res(8'd9),
    .busy(b_busy), .owner(b_owner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_b = 1'b0;
    #2;
    rst_b = 1'b1;
    tick();
  endtask

  // One full operation for requester idx, entered in IDLE with inputs set.
  task automatic do_op(input int unsigned idx, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r, input int unsigned ops_stall,
                       input int unsigned resp_stall, input logic drop,
                       input logic [3:0] late);
    logic [3:0] oh;
    oh = 4'(1 << idx);
    #1;
    chk("idle_req_rdy", 32'(req_rdy), 32'(oh));
    chk("idle_busy", 32'(busy), 32'd0);
    tick();
    if (drop) req_val = req_val & ~oh;
    req_val = req_val | late;
    #1;
    chk("issue_val", 32'(gcd_ops_val), 32'd1);
    chk("issue_a", 32'(gcd_ops_a), 32'(a));
    chk("issue_b", 32'(gcd_ops_b), 32'(b));
    chk("issue_owner", 32'(owner), idx);
    chk("issue_busy", 32'(busy), 32'd1);
    chk("issue_req_rdy", 32'(req_rdy), 32'd0);
    for (int unsigned s = 0; s < ops_stall; s++) begin
      tick();
      chk("stall_a", 32'(gcd_ops_a), 32'(a));
      chk("stall_b", 32'(gcd_ops_b), 32'(b));
      chk("stall_val", 32'(gcd_ops_val), 32'd1);
      chk("stall_req_rdy", 32'(req_rdy), 32'd0);
    end
    gcd_ops_rdy = 1'b1;
    tick();
    gcd_ops_rdy = 1'b0;
    #1;
    chk("wait_res_rdy", 32'(gcd_res_rdy), 32'd1);
    chk("wait_ops_val", 32'(gcd_ops_val), 32'd0);
    gcd_res_val = 1'b1;
    gcd_res     = r;
    tick();
    gcd_res_val = 1'b0;
    gcd_res     = 8'hAA;
    #1;
    chk("ret_resp_val", 32'(resp_val), 32'(oh));
    chk("ret_resp_data", 32'(resp_data), 32'(r));
    chk("ret_res_rdy", 32'(gcd_res_rdy), 32'd0);
    resp_rdy = ~oh;
    for (int unsigned s = 0; s < resp_stall; s++) begin
      tick();
      chk("hold_resp_val", 32'(resp_val), 32'(oh));
      chk("hold_resp_data", 32'(resp_data), 32'(r));
      chk("hold_req_rdy", 32'(req_rdy), 32'd0);
      chk("hold_owner", 32'(owner), idx);
    end
    resp_rdy = oh;
    tick();
    resp_rdy = '0;
    #1;
    chk("done_resp_val", 32'(resp_val), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_owner", 32'(owner), 32'd0);
  endtask

  initial begin
    rst_b = 1'b0;
    req_val = '0; req_a = '0; req_b = '0; resp_rdy = '0;
    gcd_ops_rdy = 1'b0; gcd_res_val = 1'b0; gcd_res = '0;
    b_req_val = '0; b_req_a = '0; b_req_b = '0;
    #2;
    req_val = 4'hF;
    #1;
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_resp_val", 32'(resp_val), 32'd0);
    chk("rst_ops_val", 32'(gcd_ops_val), 32'd0);
    chk("rst_res_rdy", 32'(gcd_res_rdy), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    req_val = '0;
    #9;
    rst_b = 1'b1;
    tick();

    // Single request from requester 2: gcd(48,18)=6.
    req_val = 4'b0100;
    req_a   = {8'd0, 8'd48, 8'd0, 8'd0};
    req_b   = {8'd0, 8'd18, 8'd0, 8'd0};
    do_op(2, 8'd48, 8'd18, 8'd6, 0, 0, 1'b1, 4'b0000);
    chk("single_rr_ptr", 32'(dut.rr_ptr), 32'd3);

    // Round robin with all four requesting continuously.
    pulse_reset();
    req_a   = {8'd14, 8'd25, 8'd9, 8'd12};
    req_b   = {8'd21, 8'd15, 8'd6, 8'd8};
    req_val = 4'hF;
    do_op(0, 8'd12, 8'd8,  8'd4, 0, 0, 1'b0, 4'b0000);
    do_op(1, 8'd9,  8'd6,  8'd3, 0, 0, 1'b0, 4'b0000);
    do_op(2, 8'd25, 8'd15, 8'd5, 0, 0, 1'b0, 4'b0000);
    do_op(3, 8'd14, 8'd21, 8'd7, 0, 0, 1'b0, 4'b0000);
    #1;
    chk("rr_fifth_grant", 32'(req_rdy), 32'b0001);
    chk("rr_ptr_wrap4", 32'(dut.rr_ptr), 32'd0);
    req_val = '0;

    // Backpressure on both sides, non-owner resp_rdy asserted while holding.
    req_a   = {8'd0, 8'd0, 8'd35, 8'd0};
    req_b   = {8'd0, 8'd0, 8'd10, 8'd0};
    req_val = 4'b0010;
    do_op(1, 8'd35, 8'd10, 8'd5, 5, 4, 1'b1, 4'b0000);

    // Late arrival of requester 0 during ISSUE, then a zero operand passes through.
    req_a   = {8'd0, 8'd0, 8'd16, 8'd0};
    req_b   = {8'd0, 8'd0, 8'd24, 8'd5};
    req_val = 4'b0010;
    do_op(1, 8'd16, 8'd24, 8'd8, 0, 2, 1'b1, 4'b0001);
    do_op(0, 8'd0, 8'd5, 8'd5, 0, 0, 1'b1, 4'b0000);

    // Asynchronous reset in WAIT.
    req_a   = {8'd9, 8'd0, 8'd0, 8'd0};
    req_b   = {8'd3, 8'd0, 8'd0, 8'd0};
    req_val = 4'b1000;
    #1;
    chk("mw_grant", 32'(req_rdy), 32'b1000);
    tick();
    gcd_ops_rdy = 1'b1;
    tick();
    gcd_ops_rdy = 1'b0;
    #1;
    chk("mw_in_wait", 32'(gcd_res_rdy), 32'd1);
    rst_b = 1'b0;
    #1;
    chk("mw_res_rdy", 32'(gcd_res_rdy), 32'd0);
    chk("mw_busy", 32'(busy), 32'd0);
    chk("mw_owner", 32'(owner), 32'd0);
    chk("mw_req_rdy", 32'(req_rdy), 32'd0);
    chk("mw_ops_a", 32'(gcd_ops_a), 32'd0);
    chk("mw_resp_data", 32'(resp_data), 32'd0);
    chk("mw_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    #2;
    req_val = '0;
    rst_b   = 1'b1;
    tick();
    tick();
    chk("mw_no_stale_resp", 32'(resp_val), 32'd0);
    chk("mw_idle_after", 32'(busy), 32'd0);

    // Three-requester wrap: req1 moves rr_ptr to 2, then 2 beats 0.
    b_req_a   = {8'd27, 8'd4, 8'd18};
    b_req_b   = {8'd18, 8'd6, 8'd27};
    b_req_val = 3'b010;
    #1;
    chk("w3_first", 32'(b_req_rdy), 32'b010);
    tick();
    b_req_val = '0;
    tick();
    tick();
    tick();
    chk("w3_ptr2", 32'(dut3.rr_ptr), 32'd2);
    chk("w3_idle", 32'(b_busy), 32'd0);
    b_req_val = 3'b101;
    #1;
    chk("w3_grant2", 32'(b_req_rdy), 32'b100);
    tick();
    b_req_val = 3'b001;
    #1;
    chk("w3_owner2", 32'(b_owner), 32'd2);
    chk("w3_ops_a", 32'(b_ops_a), 32'd27);
    tick();
    tick();
    chk("w3_resp2", 32'(b_resp_val), 32'b100);
    chk("w3_resp_data", 32'(b_resp_data), 32'd9);
    tick();
    chk("w3_ptr_wrap", 32'(dut3.rr_ptr), 32'd0);
    chk("w3_grant0", 32'(b_req_rdy), 32'b001);
    tick();
    b_req_val = '0;
    #1;
    chk("w3_owner0", 32'(b_owner), 32'd0);
    chk("w3_ops_a0", 32'(b_ops_a), 32'd18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
